// File: rtl/prog_loader_if.sv
// Byte-stream handshake between an image source and the loader.
interface prog_loader_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready
  );

  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready
  );
endinterface

// File: rtl/prog_loader.sv
// Serial boot loader: parses a counted, XOR-checked image
// and streams its words into instruction memory.
module prog_loader #(
  parameter int          MAX_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  prog_loader_if.slave  bus,
  output logic          imem_we,
  output logic [31:0]   imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          cpu_hold,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  state_t      state;
  logic [15:0] count;
  logic [15:0] k;
  logic [1:0]  bcnt;
  logic [23:0] part;
  logic [7:0]  csum;

  logic        accept;
  logic [7:0]  d;
  logic [15:0] n_next;
  logic [31:0] woff;
  logic        n_big;

  assign bus.byte_ready = reset &&
    (state == HDR_HI || state == HDR_LO ||
     state == DATA   || state == CSUM);

  assign accept = bus.byte_valid && bus.byte_ready;
  assign d      = bus.byte_data;
  assign n_next = {count[15:8], d};
  assign woff   = {14'b0, k, 2'b00};
  assign n_big  = {16'b0, n_next} > 32'(MAX_WORDS);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= HDR_HI;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= 32'h0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      count      <= 16'h0;
      k          <= 16'h0;
      bcnt       <= 2'd0;
      part       <= 24'h0;
      csum       <= 8'h0;
    end else begin
      imem_we <= 1'b0;
      if (accept) begin
        unique case (state)
          HDR_HI: begin
            count[15:8] <= d;
            csum        <= csum ^ d;
            state       <= HDR_LO;
          end
          HDR_LO: begin
            count <= n_next;
            csum  <= csum ^ d;
            if (n_next == 16'h0) begin
              state <= CSUM;
            end else if (n_big) begin
              state <= ERR;
              err   <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
          DATA: begin
            csum <= csum ^ d;
            bcnt <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              imem_we    <= 1'b1;
              imem_wdata <= {part, d};
              imem_addr  <= BASE_ADDR + woff;
              k          <= k + 16'd1;
              if ((k + 16'd1) == count)
                state <= CSUM;
            end else begin
              part <= {part[15:0], d};
            end
          end
          CSUM: begin
            if (d == csum) begin
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: good, bad-checksum, empty,
// oversize, gapped and reset-interrupted images.
module tb_prog_loader;
  logic        clk;
  logic        reset;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int checks;
  int errors;
  int wtotal;
  logic [31:0] waddr [64];
  logic [31:0] wdata [64];

  prog_loader_if bus ();

  prog_loader #(
    .MAX_WORDS (256),
    .BASE_ADDR (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial wtotal = 0;
  always @(negedge clk) begin
    if (imem_we) begin
      waddr[wtotal % 64] = imem_addr;
      wdata[wtotal % 64] = imem_wdata;
      wtotal = wtotal + 1;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b,
                      input int gap);
    int n;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'($urandom);
    end
    @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    n = 0;
    while (!bus.byte_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.byte_ready)
      chk("send_ready", 32'(bus.byte_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.byte_valid = 1'b0;
  endtask

  task automatic offer(input logic [7:0] b);
    @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    @(posedge clk);
    #1;
    bus.byte_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic send_img(input logic [7:0] cs,
                          input int maxgap);
    logic [7:0] img [10];
    img = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00,
            8'h05, 8'h20, 8'h09, 8'h00, 8'h0A};
    for (int i = 0; i < 10; i++)
      send(img[i], maxgap == 0 ? 0 :
           int'($urandom_range(maxgap)));
    send(cs, maxgap == 0 ? 0 :
         int'($urandom_range(maxgap)));
  endtask

  task automatic chk_writes(input string tag,
                            input int base);
    chk({tag, "_nw"}, 32'(wtotal - base), 32'd2);
    chk({tag, "_a0"}, waddr[base % 64], 32'h0);
    chk({tag, "_d0"}, wdata[base % 64], 32'h20080005);
    chk({tag, "_a1"}, waddr[(base + 1) % 64], 32'h4);
    chk({tag, "_d1"}, wdata[(base + 1) % 64], 32'h2009000A);
  endtask

  int base;

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_we",   32'(imem_we),        32'd0);
    chk("rst_addr", imem_addr,           32'h0);
    chk("rst_data", imem_wdata,          32'h0);
    chk("rst_hold", 32'(cpu_hold),       32'd1);
    chk("rst_done", 32'(done),           32'd0);
    chk("rst_err",  32'(err),            32'd0);
    chk("rst_rdy",  32'(bus.byte_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_rdy", 32'(bus.byte_ready), 32'd1);

    base = wtotal;
    send_img(8'h0C, 0);
    @(negedge clk);
    chk("g_done", 32'(done),           32'd1);
    chk("g_hold", 32'(cpu_hold),       32'd0);
    chk("g_err",  32'(err),            32'd0);
    chk("g_rdy",  32'(bus.byte_ready), 32'd0);
    chk_writes("g", base);
    offer(8'h55);
    @(negedge clk);
    chk("g_ign", 32'(wtotal - base), 32'd2);

    do_reset();
    @(negedge clk);
    chk("rd_hold", 32'(cpu_hold), 32'd1);
    chk("rd_done", 32'(done),     32'd0);

    base = wtotal;
    send_img(8'h0D, 0);
    @(negedge clk);
    chk("b_err",  32'(err),            32'd1);
    chk("b_done", 32'(done),           32'd0);
    chk("b_hold", 32'(cpu_hold),       32'd1);
    chk("b_rdy",  32'(bus.byte_ready), 32'd0);
    chk_writes("b", base);

    do_reset();
    base = wtotal;
    send(8'h00, 0);
    send(8'h00, 0);
    send(8'h00, 0);
    @(negedge clk);
    chk("z_done", 32'(done),         32'd1);
    chk("z_nw",   32'(wtotal - base), 32'd0);

    do_reset();
    base = wtotal;
    send(8'h01, 0);
    send(8'h01, 0);
    @(negedge clk);
    chk("o_err", 32'(err), 32'd1);
    for (int i = 0; i < 6; i++)
      offer(8'(i));
    @(negedge clk);
    chk("o_err2", 32'(err),            32'd1);
    chk("o_done", 32'(done),           32'd0);
    chk("o_nw",   32'(wtotal - base),  32'd0);

    do_reset();
    base = wtotal;
    send_img(8'h0C, 4);
    @(negedge clk);
    chk("r_done", 32'(done), 32'd1);
    chk_writes("r", base);

    do_reset();
    base = wtotal;
    send(8'h00, 0);
    send(8'h02, 0);
    send(8'h20, 0);
    send(8'h08, 0);
    do_reset();
    repeat (3) @(negedge clk);
    chk("m_nw", 32'(wtotal - base), 32'd0);
    send_img(8'h0C, 0);
    @(negedge clk);
    chk("m_done", 32'(done), 32'd1);
    chk_writes("m", base);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
